// File: rtl/bus_codes_pkg.sv
// Shared bus destination codes, FSM state type and width defaults for the
// destination register bank and the bus source multiplexer.
package bus_codes_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CODE_W_DEF = 5;
  localparam int ONEHOT_W   = 32;

  // Destination / read-select code map.
  localparam logic [4:0] CODE_INVALID = 5'h00;
  localparam logic [4:0] CODE_R0      = 5'h01;
  localparam logic [4:0] CODE_R15     = 5'h10;
  localparam logic [4:0] CODE_HI      = 5'h11;
  localparam logic [4:0] CODE_LO      = 5'h12;
  localparam logic [4:0] CODE_ZHI     = 5'h13;
  localparam logic [4:0] CODE_ZLO     = 5'h14;
  localparam logic [4:0] CODE_PC      = 5'h15;
  localparam logic [4:0] CODE_MDR     = 5'h16;
  localparam logic [4:0] CODE_OUTPORT = 5'h17;
  localparam logic [4:0] CODE_MAR     = 5'h18;

  // Storage is a flat array indexed by (code - 1).
  localparam int NUM_REGS  = 24;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_ACK
  } bank_state_e;

  // True for codes that name a real register (r0 .. mar).
  function automatic logic code_is_valid(input logic [31:0] code);
    return (code >= 32'(CODE_R0)) && (code <= 32'(CODE_MAR));
  endfunction

  // Storage index for a valid code.
  function automatic logic [REG_IDX_W-1:0] code_to_idx(input logic [31:0] code);
    return REG_IDX_W'(code - 32'd1);
  endfunction

endpackage

// File: rtl/decoder_5_to_32.sv
// One-hot destination decoder: bit <code> is set only while the bank is in
// its write cycle and the staged code names a real register.
module decoder_5_to_32
  import bus_codes_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic                write_en_i,
  input  logic [CODE_W-1:0]   code_i,
  output logic [ONEHOT_W-1:0] onehot_o
);

  // Gated one-hot decode of the staged code.
  always_comb begin
    // NOTE: default every combinational output first so no path can infer a latch.
    onehot_o = '0;
    if (write_en_i && code_is_valid(32'(code_i))) begin
      onehot_o[5'(code_i)] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_dest_reg_bank.sv
// Bus destination register bank: a request/ack handshake stages a code and a
// bus value, writes the decoded register one cycle later and acknowledges.
// A registered read port returns any register by code (all ones if invalid).
// Optional build macro R0_HARDWIRED_ZERO_EN makes r0 a constant zero.
module bus_dest_reg_bank
  import bus_codes_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [DATA_W-1:0]   bus_in,
  input  logic [CODE_W-1:0]   dest_select,
  input  logic                load_req,
  output logic                load_ack,
  output logic                load_err,
  output logic [ONEHOT_W-1:0] load_enable,
  input  logic [CODE_W-1:0]   rd_select,
  output logic [DATA_W-1:0]   rd_data,
  output logic [DATA_W-1:0]   hi_q,
  output logic [DATA_W-1:0]   lo_q,
  output logic [DATA_W-1:0]   pc_q,
  output logic [DATA_W-1:0]   mdr_q,
  output logic [DATA_W-1:0]   mar_q,
  output logic [DATA_W-1:0]   outport_q
);

  localparam logic [REG_IDX_W-1:0] IDX_HI      = code_to_idx(32'(CODE_HI));
  localparam logic [REG_IDX_W-1:0] IDX_LO      = code_to_idx(32'(CODE_LO));
  localparam logic [REG_IDX_W-1:0] IDX_PC      = code_to_idx(32'(CODE_PC));
  localparam logic [REG_IDX_W-1:0] IDX_MDR     = code_to_idx(32'(CODE_MDR));
  localparam logic [REG_IDX_W-1:0] IDX_MAR     = code_to_idx(32'(CODE_MAR));
  localparam logic [REG_IDX_W-1:0] IDX_OUTPORT = code_to_idx(32'(CODE_OUTPORT));

  bank_state_e         state_q;
  logic [CODE_W-1:0]   code_q;
  logic [DATA_W-1:0]   data_q;
  logic                ack_q;
  logic                err_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   rd_data_d;
  logic [ONEHOT_W-1:0] onehot;
  logic                wr_en;

  decoder_5_to_32 #(
    .CODE_W (CODE_W)
  ) u_decoder (
    .write_en_i (state_q == ST_WRITE),
    .code_i     (code_q),
    .onehot_o   (onehot)
  );

  // Storage write enable; r0 may be excluded while its strobe still pulses.
  always_comb begin
    wr_en = |onehot;
`ifdef R0_HARDWIRED_ZERO_EN
    if (code_q == CODE_W'(CODE_R0)) begin
      wr_en = 1'b0;
    end
`endif
  end

  // Handshake FSM: stage request, write cycle, then ack until request drops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (clr) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_req) begin
            code_q  <= dest_select;
            data_q  <= bus_in;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          err_q   <= !code_is_valid(32'(code_q));
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          if (load_req) begin
            ack_q <= 1'b1;
          end else begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Register storage: cleared by clr, written in the write cycle only.
  always_ff @(posedge clk) begin
    if (clr) begin
      // NOTE: the storage array is flops, not RAM, and clr must clear it, so every entry is reset.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[code_to_idx(32'(code_q))] <= data_q;
    end
  end

  // Read mux on pre-edge storage; no bypass of a same-edge write.
  always_comb begin
    rd_data_d = '1;
    if (code_is_valid(32'(rd_select))) begin
      rd_data_d = regs_q[code_to_idx(32'(rd_select))];
    end
`ifdef R0_HARDWIRED_ZERO_EN
    if (rd_select == CODE_W'(CODE_R0)) begin
      rd_data_d = '0;
    end
`endif
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign load_ack    = ack_q;
  assign load_err    = err_q;
  assign load_enable = onehot;
  assign rd_data     = rd_data_q;
  assign hi_q        = regs_q[IDX_HI];
  assign lo_q        = regs_q[IDX_LO];
  assign pc_q        = regs_q[IDX_PC];
  assign mdr_q       = regs_q[IDX_MDR];
  assign mar_q       = regs_q[IDX_MAR];
  assign outport_q   = regs_q[IDX_OUTPORT];

endmodule

// File: tb/tb_bus_dest_reg_bank.sv
// Directed testbench for bus_dest_reg_bank (default 32-bit data, 5-bit codes).
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.
module tb_bus_dest_reg_bank;

  logic        clk;
  logic        clr;
  logic [31:0] bus_in;
  logic [4:0]  dest_select;
  logic        load_req;
  logic        load_ack;
  logic        load_err;
  logic [31:0] load_enable;
  logic [4:0]  rd_select;
  logic [31:0] rd_data;
  logic [31:0] hi_q, lo_q, pc_q, mdr_q, mar_q, outport_q;

  int tests_run    = 0;
  int tests_failed = 0;
  int en_cycles    = 0;

  bus_dest_reg_bank dut (
    .clk         (clk),
    .clr         (clr),
    .bus_in      (bus_in),
    .dest_select (dest_select),
    .load_req    (load_req),
    .load_ack    (load_ack),
    .load_err    (load_err),
    .load_enable (load_enable),
    .rd_select   (rd_select),
    .rd_data     (rd_data),
    .hi_q        (hi_q),
    .lo_q        (lo_q),
    .pc_q        (pc_q),
    .mdr_q       (mdr_q),
    .mar_q       (mar_q),
    .outport_q   (outport_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with any strobe bit set (sampled mid-cycle).
  always @(negedge clk) if (load_enable != 32'h0) en_cycles++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complete one handshake; the ack must appear within a bounded number of cycles.
  task automatic do_write(input logic [4:0] code, input logic [31:0] data);
    bit seen = 0;
    dest_select = code;
    bus_in      = data;
    load_req    = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (load_ack === 1'b1) seen = 1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL write_ack_timeout code=%h: ack got 0, expected 1", code);
    end
    load_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clr = 1'b1; load_req = 1'b0; bus_in = '0; dest_select = '0; rd_select = 5'h06;
    tick(); tick();
    tests_run++; if (load_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %b expected 0", load_ack); end
    tests_run++; if (load_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", load_err); end
    tests_run++; if (load_enable !== 32'h0) begin tests_failed++; $display("FAIL reset_enable: got %h expected 0", load_enable); end
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    tests_run++;
    if ({hi_q, lo_q, pc_q, mdr_q, mar_q, outport_q} !== 192'h0) begin
      tests_failed++; $display("FAIL reset_views: hi=%h lo=%h pc=%h mdr=%h mar=%h out=%h expected all 0", hi_q, lo_q, pc_q, mdr_q, mar_q, outport_q);
    end
    clr = 1'b0;
    tick();
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL reset_r5_read: got %h expected 0", rd_data); end
    rd_select = 5'h00; tick();
    tests_run++; if (rd_data !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL read_code00: got %h expected ffffffff", rd_data); end
    rd_select = 5'h19; tick();
    tests_run++; if (rd_data !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL read_code19: got %h expected ffffffff", rd_data); end
  endtask

  task automatic test_basic_write();
    dest_select = 5'h06; bus_in = 32'hDEAD_BEEF; load_req = 1'b1; rd_select = 5'h06;
    tick(); // edge n: captured, now in write cycle
    tests_run++; if (load_enable !== 32'h0000_0040) begin tests_failed++; $display("FAIL basic_enable: got %h expected 00000040", load_enable); end
    tests_run++; if (load_ack !== 1'b0) begin tests_failed++; $display("FAIL basic_ack_n: got %b expected 0", load_ack); end
    tick(); // edge n+1: register written
    tests_run++; if (load_enable !== 32'h0) begin tests_failed++; $display("FAIL basic_enable_off: got %h expected 0", load_enable); end
    tests_run++; if (load_ack !== 1'b0) begin tests_failed++; $display("FAIL basic_ack_n1: got %b expected 0", load_ack); end
    tick(); // edge n+2: ack
    tests_run++; if (load_ack !== 1'b1) begin tests_failed++; $display("FAIL basic_ack_n2: got %b expected 1", load_ack); end
    tests_run++; if (load_err !== 1'b0) begin tests_failed++; $display("FAIL basic_err: got %b expected 0", load_err); end
    load_req = 1'b0;
    tick();
    tests_run++; if (load_ack !== 1'b0) begin tests_failed++; $display("FAIL basic_ack_drop: got %b expected 0", load_ack); end
    tests_run++; if (rd_data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL basic_read: got %h expected deadbeef", rd_data); end
  endtask

  task automatic test_invalid_code();
    int en0 = en_cycles;
    dest_select = 5'h1F; bus_in = 32'h1357_9BDF; load_req = 1'b1; rd_select = 5'h06;
    tick();
    tests_run++; if (load_enable !== 32'h0) begin tests_failed++; $display("FAIL inv_enable: got %h expected 0", load_enable); end
    tick();
    tests_run++; if (load_err !== 1'b1) begin tests_failed++; $display("FAIL inv_err_ack_state: got %b expected 1", load_err); end
    tick();
    tests_run++; if ({load_ack, load_err} !== 2'b11) begin tests_failed++; $display("FAIL inv_ack_err: got %b expected 11", {load_ack, load_err}); end
    load_req = 1'b0;
    tick();
    tests_run++; if ({load_ack, load_err} !== 2'b00) begin tests_failed++; $display("FAIL inv_release: got %b expected 00", {load_ack, load_err}); end
    tests_run++; if (en_cycles != en0) begin tests_failed++; $display("FAIL inv_no_strobe: got %0d strobe cycles expected 0", en_cycles - en0); end
    tests_run++; if (rd_data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL inv_r5_kept: got %h expected deadbeef", rd_data); end
    tests_run++;
    if ({hi_q, lo_q, pc_q, mdr_q, mar_q, outport_q} !== 192'h0) begin
      tests_failed++; $display("FAIL inv_views: hi=%h lo=%h pc=%h mdr=%h mar=%h out=%h expected all 0", hi_q, lo_q, pc_q, mdr_q, mar_q, outport_q);
    end
  endtask

  task automatic test_hold_req();
    int en0 = en_cycles;
    bit seen = 0;
    dest_select = 5'h15; bus_in = 32'hA5A5_0001; load_req = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (load_ack === 1'b1) seen = 1;
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL hold_ack_timeout: ack got 0, expected 1"); end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++; if (load_ack !== 1'b1) begin tests_failed++; $display("FAIL hold_ack_cycle%0d: got %b expected 1", i, load_ack); end
    end
    tests_run++; if (en_cycles - en0 != 1) begin tests_failed++; $display("FAIL hold_one_strobe: got %0d expected 1", en_cycles - en0); end
    tests_run++; if (pc_q !== 32'hA5A5_0001) begin tests_failed++; $display("FAIL hold_pc: got %h expected a5a50001", pc_q); end
    load_req = 1'b0;
    tick(); tick();
    tests_run++; if (load_ack !== 1'b0) begin tests_failed++; $display("FAIL hold_ack_drop: got %b expected 0", load_ack); end
    tests_run++; if (en_cycles - en0 != 1) begin tests_failed++; $display("FAIL hold_no_rewrite: got %0d expected 1", en_cycles - en0); end
  endtask

  task automatic test_capture_ignore();
    bit seen = 0;
    dest_select = 5'h18; bus_in = 32'h1; load_req = 1'b1;
    tick(); // captured
    bus_in = 32'h2; dest_select = 5'h11;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (load_ack === 1'b1) seen = 1;
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL capture_ack_timeout: ack got 0, expected 1"); end
    load_req = 1'b0;
    tick();
    tests_run++; if (mar_q !== 32'h1) begin tests_failed++; $display("FAIL capture_mar: got %h expected 00000001", mar_q); end
    tests_run++; if (hi_q !== 32'h0) begin tests_failed++; $display("FAIL capture_hi_untouched: got %h expected 0", hi_q); end
  endtask

  task automatic test_views_and_read();
    do_write(5'h11, 32'h1111_0011);
    do_write(5'h12, 32'h2222_0012);
    do_write(5'h16, 32'h3333_0016);
    do_write(5'h17, 32'h4444_0017);
    do_write(5'h13, 32'h5555_0013);
    tests_run++;
    if ({hi_q, lo_q, mdr_q, outport_q} !== {32'h1111_0011, 32'h2222_0012, 32'h3333_0016, 32'h4444_0017}) begin
      tests_failed++; $display("FAIL views: hi=%h lo=%h mdr=%h out=%h expected 11110011 22220012 33330016 44440017", hi_q, lo_q, mdr_q, outport_q);
    end
    rd_select = 5'h13; tick();
    tests_run++; if (rd_data !== 32'h5555_0013) begin tests_failed++; $display("FAIL read_zhi: got %h expected 55550013", rd_data); end
    rd_select = 5'h15; tick();
    tests_run++; if (rd_data !== 32'hA5A5_0001) begin tests_failed++; $display("FAIL read_pc: got %h expected a5a50001", rd_data); end
  endtask

  task automatic test_read_during_write();
    do_write(5'h06, 32'hCAFE_F00D);
    rd_select = 5'h06; dest_select = 5'h06; bus_in = 32'h0BAD_F00D; load_req = 1'b1;
    tick(); // edge n
    tick(); // edge n+1: write and read at same edge
    tests_run++; if (rd_data !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL rdw_old_value: got %h expected cafef00d", rd_data); end
    tick();
    tests_run++; if (rd_data !== 32'h0BAD_F00D) begin tests_failed++; $display("FAIL rdw_new_value: got %h expected 0badf00d", rd_data); end
    load_req = 1'b0;
    tick();
  endtask

  task automatic test_clr_during_write();
    dest_select = 5'h12; bus_in = 32'h0000_0055; load_req = 1'b1;
    tick(); // in write cycle
    tests_run++; if (load_enable !== 32'h0004_0000) begin tests_failed++; $display("FAIL clr_pre_enable: got %h expected 00040000", load_enable); end
    clr = 1'b1; // load_req stays high: clr must win
    tick();
    tests_run++; if ({load_ack, load_err} !== 2'b00) begin tests_failed++; $display("FAIL clr_ack_err: got %b expected 00", {load_ack, load_err}); end
    tests_run++; if (load_enable !== 32'h0) begin tests_failed++; $display("FAIL clr_enable: got %h expected 0", load_enable); end
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL clr_rd_data: got %h expected 0", rd_data); end
    tests_run++;
    if ({hi_q, lo_q, pc_q, mdr_q, mar_q, outport_q} !== 192'h0) begin
      tests_failed++; $display("FAIL clr_views: hi=%h lo=%h pc=%h mdr=%h mar=%h out=%h expected all 0", hi_q, lo_q, pc_q, mdr_q, mar_q, outport_q);
    end
    clr = 1'b0; load_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({load_ack, load_enable, lo_q} !== 65'h0) begin
        tests_failed++; $display("FAIL clr_idle_cycle%0d: ack=%b en=%h lo=%h expected 0 0 0", i, load_ack, load_enable, lo_q);
      end
    end
  endtask

  task automatic test_r0();
    logic [31:0] exp_r0;
`ifdef R0_HARDWIRED_ZERO_EN
    exp_r0 = 32'h0;
`else
    exp_r0 = 32'h1234_5678;
`endif
    dest_select = 5'h01; bus_in = 32'h1234_5678; load_req = 1'b1;
    tick();
    tests_run++; if (load_enable !== 32'h0000_0002) begin tests_failed++; $display("FAIL r0_enable: got %h expected 00000002", load_enable); end
    tick(); tick();
    tests_run++; if ({load_ack, load_err} !== 2'b10) begin tests_failed++; $display("FAIL r0_ack_err: got %b expected 10", {load_ack, load_err}); end
    load_req = 1'b0; rd_select = 5'h01;
    tick(); tick();
    tests_run++; if (rd_data !== exp_r0) begin tests_failed++; $display("FAIL r0_read: got %h expected %h", rd_data, exp_r0); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_invalid_code();
    test_hold_req();
    test_capture_ignore();
    test_views_and_read();
    test_read_during_write();
    test_clr_during_write();
    test_r0();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
